// File: rtl/sobel_edge_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : sobel_edge_pipe_if
// Brief    : Window-in / edge-out handshake bundle for the Sobel edge pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface sobel_edge_pipe_if #(
    parameter int PIXEL_W = 4,
    parameter int OUT_W   = 2
);
    localparam int MAG_W = PIXEL_W + 3;

    logic                   in_valid;
    logic                   in_ready;
    logic [9*PIXEL_W-1:0]   pixel_data;
    logic                   thresh_mode;
    logic [MAG_W-1:0]       threshold;
    logic [OUT_W-1:0]       edge_val;
    logic                   edge_valid;
    logic                   edge_ready;

    modport master (
        output in_valid, pixel_data, thresh_mode, threshold, edge_ready,
        input  in_ready, edge_val, edge_valid
    );

    modport slave (
        input  in_valid, pixel_data, thresh_mode, threshold, edge_ready,
        output in_ready, edge_val, edge_valid
    );
endinterface
`default_nettype wire

// File: rtl/sobel_edge_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sobel_edge_pipe
// Brief    : 4-stage 3x3 Sobel gradient-magnitude engine with valid/ready flow.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_edge_pipe #(
    parameter int PIXEL_W = 4,
    parameter int OUT_W   = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    sobel_edge_pipe_if.slave  bus
);
    localparam int SUM_W = PIXEL_W + 2;
    localparam int SQ_W  = 2 * SUM_W + 1;
    localparam int MAG_W = PIXEL_W + 3;

    logic                 w_stall;
    logic [3:0]           r_valid;
    logic [PIXEL_W-1:0]   w_px [9];
    logic [SUM_W-1:0]     w_row0, w_row2, w_col0, w_col2;
    logic [SUM_W-1:0]     r_row0, r_row2, r_col0, r_col2;
    logic [SUM_W-1:0]     r_gx, r_gy;
    logic [SQ_W-1:0]      w_sq, r_sq;
    logic                 r_mode1, r_mode2, r_mode3;
    logic [MAG_W-1:0]     r_thr1, r_thr2, r_thr3;
    logic [MAG_W-1:0]     w_root, w_trial;
    logic [2*MAG_W-1:0]   w_trialSq, w_sqWide;
    logic [OUT_W-1:0]     w_scaled, w_edgeNext, r_edgeVal;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            w_px[i] = bus.pixel_data[i*PIXEL_W +: PIXEL_W];
        end
    end

    // Pixel index is 3*row + col; centre taps carry weight 2.
    assign w_row0 = SUM_W'(w_px[0]) + (SUM_W'(w_px[1]) << 1) + SUM_W'(w_px[2]);
    assign w_row2 = SUM_W'(w_px[6]) + (SUM_W'(w_px[7]) << 1) + SUM_W'(w_px[8]);
    assign w_col0 = SUM_W'(w_px[0]) + (SUM_W'(w_px[3]) << 1) + SUM_W'(w_px[6]);
    assign w_col2 = SUM_W'(w_px[2]) + (SUM_W'(w_px[5]) << 1) + SUM_W'(w_px[8]);

    assign w_sq = SQ_W'(r_gx) * SQ_W'(r_gx) + SQ_W'(r_gy) * SQ_W'(r_gy);

    // Greedy bit-by-bit floor(sqrt): keep each root bit whose square still fits.
    assign w_sqWide = {{(2*MAG_W-SQ_W){1'b0}}, r_sq};
    always_comb begin
        w_root    = '0;
        w_trial   = '0;
        w_trialSq = '0;
        for (int b = MAG_W - 1; b >= 0; b--) begin
            w_trial   = w_root | (MAG_W'(1) << b);
            w_trialSq = {{MAG_W{1'b0}}, w_trial} * {{MAG_W{1'b0}}, w_trial};
            if (w_trialSq <= w_sqWide) begin
                w_root = w_trial;
            end
        end
    end

    generate
        if (OUT_W < MAG_W) begin : g_scaleShift
            assign w_scaled = OUT_W'(w_root >> (MAG_W - OUT_W));
        end else begin : g_scaleExtend
            assign w_scaled = OUT_W'(w_root);
        end
    endgenerate

    assign w_edgeNext = r_mode3 ? {OUT_W{w_root >= r_thr3}} : w_scaled;

    assign w_stall        = r_valid[3] && !bus.edge_ready;
    assign bus.in_ready   = !w_stall;
    assign bus.edge_valid = r_valid[3];
    assign bus.edge_val   = r_edgeVal;

    // Data registers only load behind a valid token, so bubbles never disturb them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= '0;
            r_row0    <= '0;
            r_row2    <= '0;
            r_col0    <= '0;
            r_col2    <= '0;
            r_mode1   <= 1'b0;
            r_thr1    <= '0;
            r_gx      <= '0;
            r_gy      <= '0;
            r_mode2   <= 1'b0;
            r_thr2    <= '0;
            r_sq      <= '0;
            r_mode3   <= 1'b0;
            r_thr3    <= '0;
            r_edgeVal <= '0;
        end else if (!w_stall) begin
            r_valid <= {r_valid[2:0], bus.in_valid};
            if (bus.in_valid) begin
                r_row0  <= w_row0;
                r_row2  <= w_row2;
                r_col0  <= w_col0;
                r_col2  <= w_col2;
                r_mode1 <= bus.thresh_mode;
                r_thr1  <= bus.threshold;
            end
            if (r_valid[0]) begin
                r_gy    <= (r_row0 >= r_row2) ? (r_row0 - r_row2) : (r_row2 - r_row0);
                r_gx    <= (r_col0 >= r_col2) ? (r_col0 - r_col2) : (r_col2 - r_col0);
                r_mode2 <= r_mode1;
                r_thr2  <= r_thr1;
            end
            if (r_valid[1]) begin
                r_sq    <= w_sq;
                r_mode3 <= r_mode2;
                r_thr3  <= r_thr2;
            end
            if (r_valid[2]) begin
                r_edgeVal <= w_edgeNext;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sobel_edge_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_edge_pipe
// Brief    : Self-checking bench for sobel_edge_pipe (directed + random stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_edge_pipe;
    localparam int PIXEL_W = 4;
    localparam int OUT_W   = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   expQ[$];
    int   gotQ[$];

    sobel_edge_pipe_if #(.PIXEL_W(PIXEL_W), .OUT_W(OUT_W)) bus ();

    sobel_edge_pipe #(.PIXEL_W(PIXEL_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain Sobel arithmetic and an integer floor-sqrt search.
    function automatic int ref_edge(logic [35:0] pix, logic mode, logic [6:0] thr);
        int p[3][3];
        int gx, gy, sq, mag;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[r][c] = int'(pix[(3*r+c)*4 +: 4]);
        gy = (p[0][0] + 2*p[0][1] + p[0][2]) - (p[2][0] + 2*p[2][1] + p[2][2]);
        gx = (p[0][0] + 2*p[1][0] + p[2][0]) - (p[0][2] + 2*p[1][2] + p[2][2]);
        if (gy < 0) gy = -gy;
        if (gx < 0) gx = -gx;
        sq  = gx*gx + gy*gy;
        mag = 0;
        while ((mag+1)*(mag+1) <= sq) mag++;
        if (mode) return (mag >= int'(thr)) ? 3 : 0;
        return mag / 32;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            expQ.delete();
            gotQ.delete();
        end else begin
            if (bus.in_valid && bus.in_ready)
                expQ.push_back(ref_edge(bus.pixel_data, bus.thresh_mode, bus.threshold));
            if (bus.edge_valid && bus.edge_ready)
                gotQ.push_back(int'(bus.edge_val));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [35:0] pix, input logic mode, input logic [6:0] thr,
                           output int lat, output logic [1:0] val);
        bus.edge_ready  = 1'b1;
        bus.pixel_data  = pix;
        bus.thresh_mode = mode;
        bus.threshold   = thr;
        bus.in_valid    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.edge_valid && lat < 20) begin
            tick();
            lat++;
        end
        val = bus.edge_val;
    endtask

    function automatic logic [35:0] rand_win();
        logic [63:0] r64;
        r64 = {$urandom(), $urandom()};
        return r64[35:0];
    endfunction

    task automatic test_reset();
        int lat;
        logic [1:0] val;
        logic [35:0] w;
        checks += 2;
        if (bus.edge_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.edge_valid); end
        if (bus.edge_val !== 2'd0) begin errors++; $display("FAIL rst_val: got %0d want 0", bus.edge_val); end
        reset = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.edge_ready = 1'b1;
            bus.in_valid   = 1'b1;
            bus.pixel_data = rand_win();
            bus.thresh_mode = 1'b1;
            bus.threshold   = 7'd0;
            tick();
        end
        checks++;
        if (bus.edge_valid !== 1'b1) begin errors++; $display("FAIL stream_valid: got %b want 1", bus.edge_valid); end
        reset = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        checks += 2;
        if (bus.edge_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", bus.edge_valid); end
        if (bus.edge_val !== 2'd0) begin errors++; $display("FAIL rst_async_val: got %0d want 0", bus.edge_val); end
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks += 2;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", bus.in_ready); end
        if (bus.edge_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b want 0", bus.edge_valid); end
        run_one(36'd0, 1'b0, 7'd0, lat, val);
        checks += 2;
        if (lat !== 4) begin errors++; $display("FAIL flat_latency: got %0d want 4", lat); end
        if (val !== 2'd0) begin errors++; $display("FAIL flat_val: got %0d want 0", val); end
        w = {9{4'hF}};
        run_one(w, 1'b0, 7'd0, lat, val);
        checks++;
        if (val !== 2'd0) begin errors++; $display("FAIL uniform15_val: got %0d want 0", val); end
        run_one(w, 1'b1, 7'd0, lat, val);
        checks++;
        if (val !== 2'd3) begin errors++; $display("FAIL thresh0_val: got %0d want 3", val); end
    endtask

    task automatic test_vertical();
        int lat;
        logic [1:0] val;
        logic [35:0] w;
        w = '0;
        w[0*4 +: 4] = 4'hF;
        w[3*4 +: 4] = 4'hF;
        w[6*4 +: 4] = 4'hF;
        run_one(w, 1'b0, 7'd0, lat, val);
        checks += 2;
        if (lat !== 4) begin errors++; $display("FAIL vert_latency: got %0d want 4", lat); end
        if (val !== 2'd1) begin errors++; $display("FAIL vert_mode0: got %0d want 1", val); end
        run_one(w, 1'b1, 7'd60, lat, val);
        checks++;
        if (val !== 2'd3) begin errors++; $display("FAIL vert_thr60: got %0d want 3", val); end
        run_one(w, 1'b1, 7'd61, lat, val);
        checks++;
        if (val !== 2'd0) begin errors++; $display("FAIL vert_thr61: got %0d want 0", val); end
    endtask

    task automatic test_corner();
        int lat;
        logic [1:0] val;
        logic [35:0] w;
        w = '0;
        w[0*4 +: 4] = 4'hF;
        w[1*4 +: 4] = 4'hF;
        w[3*4 +: 4] = 4'hF;
        run_one(w, 1'b0, 7'd0, lat, val);
        checks++;
        if (val !== 2'd1) begin errors++; $display("FAIL corner_mode0: got %0d want 1", val); end
        run_one(w, 1'b1, 7'd50, lat, val);
        checks++;
        if (val !== 2'd3) begin errors++; $display("FAIL corner_thr50: got %0d want 3", val); end
        run_one(w, 1'b1, 7'd64, lat, val);
        checks++;
        if (val !== 2'd0) begin errors++; $display("FAIL corner_thr64: got %0d want 0", val); end
        run_one(w, 1'b1, 7'd63, lat, val);
        checks++;
        if (val !== 2'd3) begin errors++; $display("FAIL corner_thr63: got %0d want 3", val); end
    endtask

    task automatic test_backpressure();
        logic [35:0] win[8];
        logic        mode[8];
        logic [6:0]  thr[8];
        int idx = 0, stallLeft = 0, cyc = 0, n;
        bit stallDone = 1'b0;
        logic [1:0] held = '0;
        for (int i = 0; i < 8; i++) begin
            win[i]  = rand_win();
            mode[i] = 1'($urandom_range(0, 1));
            thr[i]  = 7'($urandom_range(0, 90));
        end
        tick();
        expQ.delete();
        gotQ.delete();
        bus.edge_ready = 1'b1;
        while ((idx < 8 || stallLeft > 0) && cyc < 100) begin
            if (!stallDone && bus.edge_valid) begin
                stallDone = 1'b1;
                stallLeft = 5;
                held = bus.edge_val;
            end
            if (stallLeft > 0) begin
                bus.edge_ready = 1'b0;
                bus.in_valid   = 1'b1;
                bus.pixel_data = 'x;
                #1;
                checks += 3;
                if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
                if (bus.edge_valid !== 1'b1) begin errors++; $display("FAIL bp_edge_valid: got %b want 1", bus.edge_valid); end
                if (bus.edge_val !== held) begin errors++; $display("FAIL bp_hold: got %0d want %0d", bus.edge_val, held); end
                stallLeft--;
            end else begin
                bus.edge_ready = 1'b1;
                if (idx < 8) begin
                    bus.in_valid    = 1'b1;
                    bus.pixel_data  = win[idx];
                    bus.thresh_mode = mode[idx];
                    bus.threshold   = thr[idx];
                    #1;
                    if (bus.in_ready) idx++;
                end else begin
                    bus.in_valid = 1'b0;
                    #1;
                end
            end
            tick();
            cyc++;
        end
        bus.in_valid   = 1'b0;
        bus.edge_ready = 1'b1;
        repeat (8) tick();
        checks += 2;
        if (!stallDone) begin errors++; $display("FAIL bp_stall_seen: got 0 want 1"); end
        if (gotQ.size() != 8 || expQ.size() != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs / %0d accepted want 8 / 8", gotQ.size(), expQ.size());
        end
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (gotQ[i] !== expQ[i]) begin errors++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, gotQ[i], expQ[i]); end
        end
    endtask

    task automatic test_reset_midpipe();
        int lat, quiet = 0;
        logic [1:0] val;
        logic [35:0] w;
        bus.edge_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid    = 1'b1;
            bus.pixel_data  = rand_win();
            bus.thresh_mode = 1'b1;
            bus.threshold   = 7'd0;
            tick();
        end
        bus.in_valid   = 1'b0;
        bus.edge_ready = 1'b0;
        tick();
        checks++;
        if (bus.edge_valid !== 1'b1) begin errors++; $display("FAIL mid_fill: got %b want 1", bus.edge_valid); end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.edge_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_drop: got %b want 0", bus.edge_valid); end
        tick();
        reset = 1'b0;
        bus.edge_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.edge_valid) quiet++;
            tick();
        end
        checks++;
        if (quiet !== 0) begin errors++; $display("FAIL mid_stale: got %0d stale cycles want 0", quiet); end
        w = '0;
        w[0*4 +: 4] = 4'hF;
        w[3*4 +: 4] = 4'hF;
        w[6*4 +: 4] = 4'hF;
        run_one(w, 1'b0, 7'd0, lat, val);
        tick();
        checks += 3;
        if (lat !== 4) begin errors++; $display("FAIL mid_latency: got %0d want 4", lat); end
        if (val !== 2'd1) begin errors++; $display("FAIL mid_val: got %0d want 1", val); end
        if (gotQ.size() != 1) begin errors++; $display("FAIL mid_outputs: got %0d want 1", gotQ.size()); end
    endtask

    task automatic test_random();
        int n = 0, cyc = 0, m;
        bit pending = 1'b0;
        logic [35:0] w = '0;
        logic        md = 1'b0;
        logic [6:0]  th = '0;
        expQ.delete();
        gotQ.delete();
        while (n < 10000 && cyc < 60000) begin
            if (!pending) begin
                w  = rand_win();
                md = 1'($urandom_range(0, 1));
                th = 7'($urandom_range(0, 95));
                if ($urandom_range(0, 1) == 1) begin
                    w[0*4 +: 4] = 4'hF;
                    w[1*4 +: 4] = 4'hF;
                    w[3*4 +: 4] = 4'hF;
                    w[2*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
                    w[6*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
                end
                pending = 1'b1;
            end
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.edge_ready  = ($urandom_range(0, 3) != 0);
            bus.pixel_data  = bus.in_valid ? w : rand_win();
            bus.thresh_mode = md;
            bus.threshold   = th;
            #1;
            if (bus.in_valid && bus.in_ready) begin
                n++;
                pending = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.in_valid   = 1'b0;
        bus.edge_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (n != 10000 || gotQ.size() != expQ.size()) begin
            errors++;
            $display("FAIL rnd_count: got %0d outputs / %0d accepted want %0d / 10000", gotQ.size(), n, expQ.size());
        end
        m = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < m; i++) begin
            checks++;
            if (gotQ[i] !== expQ[i]) begin errors++; $display("FAIL rnd_edge[%0d]: got %0d want %0d", i, gotQ[i], expQ[i]); end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.pixel_data  = '0;
        bus.thresh_mode = 1'b0;
        bus.threshold   = '0;
        bus.edge_ready  = 1'b1;
        repeat (3) tick();
        test_reset();
        test_vertical();
        test_corner();
        test_backpressure();
        test_reset_midpipe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sobel_edge_pipe.md
Name: sobel_edge_pipe

Overview:
- Pipelined, parametrised 3x3 Sobel gradient-magnitude engine. Accepts one 3x3 pixel window per cycle and outputs a compressed edge strength per window.
- Sits between the window line-buffer and the edge-map writer.
- Adds the following over the combinational single-cycle detector:
  - PIXEL_W / OUT_W generality
  - registered 4-stage pipeline
  - valid/ready backpressure
  - a runtime binary-threshold mode

Parameters:
- PIXEL_W, 4: bits per input pixel (unsigned).
- OUT_W, 2: bits of edge output.
- Derived, not overridable:
  - SUM_W = PIXEL_W+2
  - SQ_W = 2*SUM_W+1
  - MAG_W = PIXEL_W+3

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  window on pixel_data is valid.
- in_ready  out  1  block can accept a window this cycle.
- pixel_data  in  9*PIXEL_W  window pixels. Pixel (r,c), r,c in 0..2, sits at bits [(3r+c)*PIXEL_W +: PIXEL_W]. Row 0 is top, col 0 is left.
- thresh_mode  in  1  0 = scaled magnitude output, 1 = binary threshold output. Sampled with the window.
- threshold  in  MAG_W  threshold for mode 1. Sampled with the window.
- edge_val  out  OUT_W  edge result.
- edge_valid  out  1  edge_val valid.
- edge_ready  in  1  downstream accepts edge_val.

Behaviour:
- Reset (async, immediate): all stage valid bits = 0, so edge_valid=0. edge_val=0. Datapath registers = 0. in_ready=1 while reset is deasserted after the first edge.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when edge_valid && edge_ready.
  - stall = edge_valid && !edge_ready. in_ready = !stall.
  - All stage registers, including valid bits, advance only when !stall. During a stall all stages hold, including bubbles; there is no bubble collapsing.
  - edge_val is held stable while edge_valid && !edge_ready.
- Latency: exactly 4 clk edges from input transfer to edge_valid with no stall. Throughput is 1 window/cycle.
- S1 (register weighted sums, mode and threshold), each SUM_W bits, no overflow:
  - rowK = p(K,0) + 2*p(K,1) + p(K,2)
  - colK = p(0,K) + 2*p(1,K) + p(2,K)
  - for K in {0,2}
- S2 (register): gy = |row0 - row2|, gx = |col0 - col2|, unsigned SUM_W bits. Compute as larger minus smaller; equal operands give 0.
- S3 (register): sq = gx*gx + gy*gy, SQ_W bits, exact.
- S4 (register output):
  - mag = floor(sqrt(sq)), MAG_W bits, exact for every sq up to 2*(4*(2^PIXEL_W-1))^2.
  - Implementation choice (ROM, or a combinational/iterative-unrolled restoring sqrt) is free, provided it is a single stage.
  - mode 0: edge_val = mag >> (MAG_W-OUT_W). If OUT_W >= MAG_W, zero-extend instead.
  - mode 1: edge_val = all ones if mag >= threshold, else 0. threshold=0 gives all ones.
- Mode and threshold travel with their window. Changing them mid-stream affects only windows accepted afterwards.
- Reset mid-operation: all in-flight windows are discarded and edge_valid drops immediately. No output appears after reset for windows accepted before reset.
- in_valid with unknown/X pixel_data while in_ready=0 must not corrupt held state.

Test Plan:
- Reset and flat field:
  - Stimulus: assert reset mid-stream; then 9 pixels = 0, mode 0.
  - Required: edge_valid=0 and edge_val=0 during reset. After reset, edge_val=0 exactly 4 cycles after acceptance. Uniform all-15 window also gives 0.
- Vertical edge (PIXEL_W=4):
  - Stimulus: column 0 all 15, rest 0, mode 0.
  - Required: gx=60, gy=0, mag=60, edge_val=60>>5=1.
- Corner:
  - Stimulus: p(0,0)=p(0,1)=p(1,0)=15, rest 0.
  - Required: gx=gy=45, sq=4050, mag=63.
  - mode 0 -> edge_val=1; mode 1 threshold=50 -> 3; mode 1 threshold=64 -> 0.
- Max magnitude:
  - Stimulus: row 0 and col 0 all 15 with p(2,0)=p(0,2)=0 variants swept exhaustively by random windows.
  - Required: edge_val matches a floor-sqrt reference model for 10k random windows in both modes.
- Backpressure:
  - Stimulus: stream 8 windows, hold edge_ready=0 for 5 cycles once edge_valid rises.
  - Required: in_ready=0 during the stall, edge_val stable, no window lost or duplicated, in-order output.
- Reset mid-pipeline:
  - Stimulus: accept 3 windows, assert reset for 1 cycle after 2 cycles.
  - Required: edge_valid=0 immediately and no stale outputs ever appear; the next accepted window emerges after 4 cycles.
